// File: rtl/ps2_rx_ctrl_if.sv
// PS/2 receive bundle: raw pins, frame-register shift port and decoded scan-code outputs.
// master = receive controller, slave = the environment (pins and frame register).
interface ps2_rx_ctrl_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        shren;
  logic        din;
  logic [10:0] frame;
  logic [7:0]  scan_code;
  logic        code_valid;
  logic        is_break;
  logic        is_ext;
  logic        frame_err;

  modport master (
    input  ps2_clk, ps2_data, frame,
    output shren, din, scan_code, code_valid, is_break, is_ext, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data, frame,
    input  shren, din, scan_code, code_valid, is_break, is_ext, frame_err
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: conditions the pins, shifts bits into an external frame register, decodes E0/F0.
// Strobes appear two cycles after the 11th shift; there is no backpressure, strobes are single-cycle.
module ps2_rx_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  ps2_rx_ctrl_if.master bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic [FCW-1:0]         filt_cnt_q;
  logic                   fclk_q, fclk_dly_q;
  logic                   sclk, sdata, fall;

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          is_break_q, is_break_d;
  logic          is_ext_q, is_ext_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          shift;
  logic          frame_ok;
  logic [7:0]    frame_data;

  assign sclk  = clk_sync_q[SYNC_STAGES-1];
  assign sdata = data_sync_q[SYNC_STAGES-1];
  assign fall  = fclk_dly_q & ~fclk_q;

  // Synchronisers and filter idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_cnt_q  <= '0;
      fclk_q      <= 1'b1;
      fclk_dly_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
      fclk_dly_q  <= fclk_q;
      if (sclk == fclk_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        fclk_q     <= sclk;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      timer_q      <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      scan_code_q  <= '0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      timer_q      <= timer_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      scan_code_q  <= scan_code_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign frame_data = bus.frame[8:1];
  assign frame_ok   = ~bus.frame[0] & bus.frame[10] & (^bus.frame[9:1]);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    timer_d      = timer_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    scan_code_d  = scan_code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    shift        = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          shift     = 1'b1;
          bit_cnt_d = 4'd1;
          timer_d   = '0;
          state_d   = RECV;
        end
      end

      RECV: begin
        if (fall) begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d = CHECK;
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          // Pending prefixes survive a timeout; the stale partial frame is overwritten later.
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          timer_d     = '0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      CHECK: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
        end else if (frame_data == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (frame_data == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else begin
          scan_code_d  = frame_data;
          is_ext_d     = ext_pend_q;
          is_break_d   = brk_pend_q;
          code_valid_d = 1'b1;
          ext_pend_d   = 1'b0;
          brk_pend_d   = 1'b0;
        end
        // A fall here can only be a very fast device; treat it as bit 1 of the next frame.
        if (fall) begin
          shift     = 1'b1;
          bit_cnt_d = 4'd1;
          timer_d   = '0;
          state_d   = RECV;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign bus.shren      = shift;
  assign bus.din        = shift & sdata;
  assign bus.scan_code  = scan_code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.is_break   = is_break_q;
  assign bus.is_ext     = is_ext_q;
  assign bus.frame_err  = frame_err_q;

endmodule
